// File: rtl/mu0_pkg.sv
// Shared MU0 datapath constants, output-register state encoding and the select-width helper.
package mu0_pkg;

    localparam int MU0_WIDTH   = 12;
    localparam int MU0_MUX_SEL = 0;
    localparam int MU0_MUX_RR  = 1;

    typedef enum logic {
        MU0_EMPTY = 1'b0,
        MU0_FULL  = 1'b1
    } mu0_obuf_e;

    function automatic int mu0_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mu0_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping modulo N.
module mu0_rr_pick
    import mu0_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = mu0_sel_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_j     = '0;
        // Walk from farthest to nearest so the nearest requester after i_last wins.
        for (int k = N; k >= 1; k--) begin
            w_j = IW'((int'(i_last) + k) % N);
            if (i_req[w_j]) begin
                o_idx   = w_j;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mu0_mux_arb.sv
// N-input registered mux with valid/ready on every port; external select or round-robin.
// Optional MU0_MUX_LOCK_EN adds a Lock input that holds round-robin on the last winner.
module mu0_mux_arb
    import mu0_pkg::*;
#(
    parameter  int WIDTH = MU0_WIDTH,
    parameter  int N     = 4,
    parameter  int MODE  = MU0_MUX_SEL,
    localparam int SEL_W = mu0_sel_w(N)
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic [N*WIDTH-1:0] In_Data,
    input  logic [N-1:0]       In_Valid,
    output logic [N-1:0]       In_Ready,
    input  logic [SEL_W-1:0]   Sel,
`ifdef MU0_MUX_LOCK_EN
    input  logic               Lock,
`endif
    output logic [WIDTH-1:0]   Out_Data,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [SEL_W-1:0]   Out_Chan
);

    mu0_obuf_e        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_chan;

    logic [SEL_W-1:0] w_cand;
    logic             w_cand_ok;
    logic             w_slot_free;
    logic             w_grant;
    logic [WIDTH-1:0] w_in [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_in[i] = In_Data[i*WIDTH +: WIDTH];
    end

    if (MODE == MU0_MUX_RR) begin : g_rr
        logic [SEL_W-1:0] r_last;
        logic [SEL_W-1:0] w_pick;
        logic             w_found;
        logic             w_unused_sel;

        assign w_unused_sel = ^Sel;

        mu0_rr_pick #(.N(N), .IW(SEL_W)) u_pick (
            .i_req   (In_Valid),
            .i_last  (r_last),
            .o_idx   (w_pick),
            .o_found (w_found)
        );

        always_comb begin
            w_cand    = w_pick;
            w_cand_ok = w_found;
`ifdef MU0_MUX_LOCK_EN
            // A locked burst keeps the previous winner while it still has data.
            if (Lock && In_Valid[r_last]) begin
                w_cand    = r_last;
                w_cand_ok = 1'b1;
            end
`endif
        end

        always_ff @(posedge Clk or negedge nReset) begin
            if (!nReset)
                r_last <= SEL_W'(N - 1);
            else if (w_grant)
                r_last <= w_cand;
        end
    end else begin : g_sel
`ifdef MU0_MUX_LOCK_EN
        logic w_unused_lock;
        assign w_unused_lock = Lock;
`endif
        assign w_cand    = Sel;
        assign w_cand_ok = ({1'b0, Sel} < (SEL_W + 1)'(N));
    end

    assign w_slot_free = (r_state == MU0_EMPTY) || Out_Ready;
    assign w_grant     = nReset && w_slot_free && w_cand_ok && In_Valid[w_cand];

    always_comb begin
        In_Ready = '0;
        if (w_grant)
            In_Ready[w_cand] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MU0_EMPTY: if (w_grant) w_state_nxt = MU0_FULL;
            MU0_FULL:  if (!w_grant && Out_Ready) w_state_nxt = MU0_EMPTY;
            default:   w_state_nxt = MU0_EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            r_state <= MU0_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Data and channel hold across a drain; only a grant overwrites them.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_data <= '0;
            r_chan <= '0;
        end else if (w_grant) begin
            r_data <= w_in[w_cand];
            r_chan <= w_cand;
        end
    end

    assign Out_Data  = r_data;
    assign Out_Valid = (r_state == MU0_FULL);
    assign Out_Chan  = r_chan;

endmodule

// File: tb/tb_mu0_mux_arb.sv
// Directed bench: MODE 0 (N=4 and N=3) and MODE 1 (N=4) instances with a scoreboard per output.
module tb_mu0_mux_arb;

    typedef struct packed {
        logic [11:0] data;
        logic [1:0]  chan;
    } exp_t;

    logic Clk, nReset;

    logic [47:0] d0;  logic [3:0] v0, r0; logic [1:0] s0; logic [11:0] od0; logic ov0, or0; logic [1:0] oc0;
    logic [35:0] d3;  logic [2:0] v3, r3; logic [1:0] s3; logic [11:0] od3; logic ov3, or3; logic [1:0] oc3;
    logic [47:0] d1;  logic [3:0] v1, r1; logic [1:0] s1; logic [11:0] od1; logic ov1, or1; logic [1:0] oc1;
`ifdef MU0_MUX_LOCK_EN
    logic lock;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   seq_a[6] = '{0, 1, 2, 3, 0, 1};
    int   seq_b[4] = '{1, 3, 1, 3};

    mu0_mux_arb #(.WIDTH(12), .N(4), .MODE(0)) u0 (
        .Clk(Clk), .nReset(nReset), .In_Data(d0), .In_Valid(v0), .In_Ready(r0), .Sel(s0),
`ifdef MU0_MUX_LOCK_EN
        .Lock(lock),
`endif
        .Out_Data(od0), .Out_Valid(ov0), .Out_Ready(or0), .Out_Chan(oc0));

    mu0_mux_arb #(.WIDTH(12), .N(3), .MODE(0)) u3 (
        .Clk(Clk), .nReset(nReset), .In_Data(d3), .In_Valid(v3), .In_Ready(r3), .Sel(s3),
`ifdef MU0_MUX_LOCK_EN
        .Lock(lock),
`endif
        .Out_Data(od3), .Out_Valid(ov3), .Out_Ready(or3), .Out_Chan(oc3));

    mu0_mux_arb #(.WIDTH(12), .N(4), .MODE(1)) u1 (
        .Clk(Clk), .nReset(nReset), .In_Data(d1), .In_Valid(v1), .In_Ready(r1), .Sel(s1),
`ifdef MU0_MUX_LOCK_EN
        .Lock(lock),
`endif
        .Out_Data(od1), .Out_Valid(ov1), .Out_Ready(or1), .Out_Chan(oc1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboards pop on every output handshake seen at the falling edge.
    always @(negedge Clk) begin
        if (nReset && ov0 && or0) begin
            chk("sb0_nonempty", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("sb0_data", 32'(od0), 32'(e0.data));
                chk("sb0_chan", 32'(oc0), 32'(e0.chan));
            end
        end
    end

    always @(negedge Clk) begin
        if (nReset && ov1 && or1) begin
            chk("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("sb1_data", 32'(od1), 32'(e1.data));
                chk("sb1_chan", 32'(oc1), 32'(e1.chan));
            end
        end
    end

    initial begin
        nReset = 1'b1;
        d0 = '0; v0 = '0; s0 = '0; or0 = 1'b0;
        d3 = '0; v3 = '0; s3 = '0; or3 = 1'b0;
        d1 = '0; v1 = '0; s1 = '0; or1 = 1'b0;
`ifdef MU0_MUX_LOCK_EN
        lock = 1'b0;
`endif
        #1 nReset = 1'b0;

        // Reset state, with a live request that must not be granted while in reset
        d0[2*12 +: 12] = 12'hABC; s0 = 2'd2; v0 = 4'b0100; or0 = 1'b1;
        #2;
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_out_data",  32'(od0), 32'h000);
        chk("rst_out_chan",  32'(oc0), 32'd0);
        chk("rst_in_ready",  32'(r0),  32'b0000);

        // MODE 0 select of channel 2
        @(negedge Clk);
        nReset = 1'b1;
        #1;
        chk("sel_in_ready", 32'(r0), 32'b0100);
        q0.push_back('{data: 12'hABC, chan: 2'd2});
        tick();
        v0 = 4'b0000;
        @(negedge Clk);
        chk("sel_out_data",  32'(od0), 32'hABC);
        chk("sel_out_chan",  32'(oc0), 32'd2);
        chk("sel_out_valid", 32'(ov0), 32'd1);

        // Stall: FULL at 0BC while channel 1 waits
        tick();
        d0[0 +: 12] = 12'h0BC; s0 = 2'd0; v0 = 4'b0001; or0 = 1'b0;
        q0.push_back('{data: 12'h0BC, chan: 2'd0});
        tick();
        d0[12 +: 12] = 12'h9AB; s0 = 2'd1; v0 = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("stall_out_data", 32'(od0), 32'h0BC);
            chk("stall_in_ready", 32'(r0),  32'b0000);
        end
        tick();
        or0 = 1'b1;
        q0.push_back('{data: 12'h9AB, chan: 2'd1});
        @(negedge Clk);
        chk("drain_in_ready", 32'(r0), 32'b0010);
        tick();
        v0 = 4'b0000;
        @(negedge Clk);
        chk("nobubble_data",  32'(od0), 32'h9AB);
        chk("nobubble_valid", 32'(ov0), 32'd1);
        @(negedge Clk);
        chk("drained_valid", 32'(ov0), 32'd0);
        chk("drained_hold",  32'(od0), 32'h9AB);

        // Asynchronous reset while FULL
        tick();
        d0[2*12 +: 12] = 12'h123; s0 = 2'd2; v0 = 4'b0100; or0 = 1'b0;
        tick();
        @(negedge Clk);
        chk("pre_rst_valid", 32'(ov0), 32'd1);
        chk("pre_rst_data",  32'(od0), 32'h123);
        #2 nReset = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(ov0), 32'd0);
        chk("mid_rst_data",     32'(od0), 32'h000);
        chk("mid_rst_chan",     32'(oc0), 32'd0);
        chk("mid_rst_in_ready", 32'(r0),  32'b0000);
        v0 = 4'b0000; or0 = 1'b1;
        @(negedge Clk);
        #1 nReset = 1'b1;

        // MODE 0 out-of-range select on N=3
        d3 = {12'h333, 12'h222, 12'h111};
        s3 = 2'd3; v3 = 3'b111; or3 = 1'b1;
        #1;
        chk("badsel_in_ready", 32'(r3), 32'b000);
        @(negedge Clk);
        chk("badsel_valid_a", 32'(ov3), 32'd0);
        @(negedge Clk);
        chk("badsel_valid_b", 32'(ov3), 32'd0);
        #1 s3 = 2'd2;
        #1;
        chk("n3_sel2_ready", 32'(r3), 32'b100);
        tick();
        v3 = 3'b000;
        @(negedge Clk);
        chk("n3_sel2_data", 32'(od3), 32'h333);
        chk("n3_sel2_chan", 32'(oc3), 32'd2);

        // MODE 1 rotation with all inputs valid
        tick();
        d1 = {12'h103, 12'h102, 12'h101, 12'h100};
        v1 = 4'b1111; or1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_all_ready", 32'(r1), 32'd1 << seq_a[i]);
            q1.push_back('{data: 12'h100 + 12'(seq_a[i]), chan: 2'(seq_a[i])});
            tick();
        end
        v1 = 4'b0000;
        @(negedge Clk);
        @(negedge Clk);
        chk("rr_all_drained", 32'(ov1), 32'd0);

        // MODE 1 sparse requesters from a fresh pointer
        #1 nReset = 1'b0;
        #2 nReset = 1'b1;
        tick();
        v1 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_sparse_ready", 32'(r1), 32'd1 << seq_b[i]);
            q1.push_back('{data: 12'h100 + 12'(seq_b[i]), chan: 2'(seq_b[i])});
            tick();
        end
        v1 = 4'b0000;
        @(negedge Clk);
        @(negedge Clk);

`ifdef MU0_MUX_LOCK_EN
        // Lock holds the burst on channel 0 until it runs dry
        #1 nReset = 1'b0;
        #2 nReset = 1'b1;
        tick();
        v1 = 4'b1111; lock = 1'b0;
        #1;
        chk("lock_first_ready", 32'(r1), 32'b0001);
        q1.push_back('{data: 12'h100, chan: 2'd0});
        tick();
        lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lock_hold_ready", 32'(r1), 32'b0001);
            q1.push_back('{data: 12'h100, chan: 2'd0});
            tick();
        end
        v1 = 4'b1110;
        #1;
        chk("lock_release_ready", 32'(r1), 32'b0010);
        q1.push_back('{data: 12'h101, chan: 2'd1});
        tick();
        v1 = 4'b0000; lock = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
`endif

        chk("sb0_empty_at_end", 32'(q0.size()), 32'd0);
        chk("sb1_empty_at_end", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
